// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - display data in, anode/segment pins out for the scan multiplexer
interface seg_scan_mux_if;
  logic        clk_d;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;

  modport master (
    output clk_d, digits, dp_in, blank,
    input  an, seg, dp, digit_sel
  );

  modport slave (
    input  clk_d, digits, dp_in, blank,
    output an, seg, dp, digit_sel
  );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit seven-segment scan mux with per-scan snapshot and anti-ghost guard
module seg_scan_mux #(
  parameter int GUARD_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_scan_mux_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  localparam logic [7:0] GUARD_LEN = 8'(GUARD_CYCLES);
  localparam logic [3:0] AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF    = SEG_ACTIVE_LOW;

  logic        s1, s2, s3, step;
  state_t      state, state_n;
  logic [1:0]  ptr, ptr_n, ptr_adv;
  logic [15:0] sh_digits, sh_digits_n;
  logic [3:0]  sh_dp, sh_dp_n;
  logic [3:0]  sh_blank, sh_blank_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  an_q, an_n;
  logic [6:0]  seg_q, seg_n;
  logic        dp_q, dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = 7'h77;
      4'hB: r = 7'h7C;
      4'hC: r = 7'h39;
      4'hD: r = 7'h5E;
      4'hE: r = 7'h79;
      default: r = 7'h71;
    endcase
    return r;
  endfunction

  assign ptr_adv = ptr + 2'd1;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    sh_digits_n = sh_digits;
    sh_dp_n     = sh_dp;
    sh_blank_n  = sh_blank;
    cnt_n       = cnt;

    if (state == IDLE) begin
      if (step) begin
        sh_digits_n = bus.digits;
        sh_dp_n     = bus.dp_in;
        sh_blank_n  = bus.blank;
        ptr_n       = 2'd0;
        if (GUARD_LEN != 8'd0) begin
          state_n = GUARD;
          cnt_n   = GUARD_LEN;
        end else begin
          state_n = SHOW;
        end
      end
    end else if (step) begin
      // A step in GUARD is handled like one in SHOW, so the guard simply restarts
      ptr_n = ptr_adv;
      if (ptr_adv == 2'd0) begin
        sh_digits_n = bus.digits;
        sh_dp_n     = bus.dp_in;
        sh_blank_n  = bus.blank;
      end
      if (GUARD_LEN != 8'd0) begin
        state_n = GUARD;
        cnt_n   = GUARD_LEN;
      end else begin
        state_n = SHOW;
      end
    end else if (state == GUARD) begin
      if (cnt <= 8'd1) begin
        state_n = SHOW;
        cnt_n   = 8'd0;
      end else begin
        cnt_n = cnt - 8'd1;
      end
    end

    // Outputs are decoded from next-state values so they settle on the same edge
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    dp_n  = DP_OFF;
    if (state_n == SHOW && !sh_blank_n[ptr_n]) begin
      an_n  = (4'b0001 << ptr_n) ^ {4{AN_ACTIVE_LOW}};
      seg_n = hex7(sh_digits_n[{ptr_n, 2'b00} +: 4]) ^ {7{SEG_ACTIVE_LOW}};
      dp_n  = sh_dp_n[ptr_n] ^ SEG_ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      step      <= 1'b0;
      state     <= IDLE;
      ptr       <= 2'd0;
      sh_digits <= 16'h0000;
      sh_dp     <= 4'h0;
      sh_blank  <= 4'h0;
      cnt       <= 8'd0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
    end else begin
      s1        <= bus.clk_d;
      s2        <= s1;
      s3        <= s2;
      step      <= s2 & ~s3;
      state     <= state_n;
      ptr       <= ptr_n;
      sh_digits <= sh_digits_n;
      sh_dp     <= sh_dp_n;
      sh_blank  <= sh_blank_n;
      cnt       <= cnt_n;
      an_q      <= an_n;
      seg_q     <= seg_n;
      dp_q      <= dp_n;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = ptr;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed bench for seg_scan_mux with guard lengths 2, 0 and 8
module tb_seg_scan_mux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_d = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  int          dut_sel = 0;
  int          checks = 0;
  int          failures = 0;

  logic [3:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [1:0] o_sel;
  logic [3:0] prev_an;
  logic [6:0] prev_seg;

  always #5 clk = ~clk;

  seg_scan_mux_if if2 ();
  seg_scan_mux_if if0 ();
  seg_scan_mux_if if8 ();

  assign if2.clk_d = clk_d;  assign if2.digits = digits;  assign if2.dp_in = dp_in;  assign if2.blank = blank;
  assign if0.clk_d = clk_d;  assign if0.digits = digits;  assign if0.dp_in = dp_in;  assign if0.blank = blank;
  assign if8.clk_d = clk_d;  assign if8.digits = digits;  assign if8.dp_in = dp_in;  assign if8.blank = blank;

  seg_scan_mux #(.GUARD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_g2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  seg_scan_mux #(.GUARD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_g0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  seg_scan_mux #(.GUARD_CYCLES(8), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_g8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  always_comb begin
    o_an  = if2.an;
    o_seg = if2.seg;
    o_dp  = if2.dp;
    o_sel = if2.digit_sel;
    if (dut_sel == 1) begin
      o_an = if0.an;  o_seg = if0.seg;  o_dp = if0.dp;  o_sel = if0.digit_sel;
    end else if (dut_sel == 2) begin
      o_an = if8.an;  o_seg = if8.seg;  o_dp = if8.dp;  o_sel = if8.digit_sel;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clk_d = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev_an  = 4'hF;
    prev_seg = 7'h7F;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, 32'(o_an), 32'h0F);
    check({tag, "_seg"}, 32'(o_seg), 32'h7F);
    check({tag, "_dp"}, 32'(o_dp), 32'h1);
    check({tag, "_sel"}, 32'(o_sel), 32'h0);
  endtask

  // Raise clk_d, expect old digit two cycles later, then gap off cycles, then the new digit
  task automatic scan_step(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic [1:0] e_sel, input int gap);
    @(negedge clk);
    clk_d = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3) begin
        check({tag, "_pre_an"}, 32'(o_an), 32'(prev_an));
        check({tag, "_pre_seg"}, 32'(o_seg), 32'(prev_seg));
      end else if (i >= 4 && i < 4 + gap) begin
        check({tag, "_guard_an"}, 32'(o_an), 32'h0F);
        check({tag, "_guard_sel"}, 32'(o_sel), 32'(e_sel));
      end else if (i == 4 + gap) begin
        check({tag, "_an"}, 32'(o_an), 32'(e_an));
        check({tag, "_seg"}, 32'(o_seg), 32'(e_seg));
        check({tag, "_dp"}, 32'(o_dp), 32'(e_dp));
        check({tag, "_sel"}, 32'(o_sel), 32'(e_sel));
      end
    end
    clk_d = 1'b0;
    repeat (16) @(negedge clk);
    check({tag, "_hold_an"}, 32'(o_an), 32'(e_an));
    check({tag, "_hold_seg"}, 32'(o_seg), 32'(e_seg));
    check({tag, "_hold_sel"}, 32'(o_sel), 32'(e_sel));
    prev_an  = e_an;
    prev_seg = e_seg;
  endtask

  initial begin
    // Reset and idle
    dut_sel = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_off("idle_g2");
    end
    dut_sel = 1;
    check_off("idle_g0");
    dut_sel = 2;
    check_off("idle_g8");

    // Basic scan with guard of 2, then snapshot behaviour
    dut_sel = 0;
    digits = 16'h4321;
    dp_in  = 4'b0010;
    blank  = 4'b0000;
    do_reset();
    scan_step("scan_d0", 4'b1110, 7'h79, 1'b1, 2'd0, 2);
    scan_step("scan_d1", 4'b1101, 7'h24, 1'b0, 2'd1, 2);
    digits = 16'hFFFF;
    scan_step("snap_d2", 4'b1011, 7'h30, 1'b1, 2'd2, 2);
    scan_step("snap_d3", 4'b0111, 7'h19, 1'b1, 2'd3, 2);
    scan_step("snap_d0", 4'b1110, 7'h0E, 1'b1, 2'd0, 2);
    scan_step("snap_d1", 4'b1101, 7'h0E, 1'b0, 2'd1, 2);

    // Blank digit with no guard
    dut_sel = 1;
    digits = 16'h8888;
    dp_in  = 4'b0000;
    blank  = 4'b0100;
    do_reset();
    scan_step("ng_d0", 4'b1110, 7'h00, 1'b1, 2'd0, 0);
    scan_step("ng_d1", 4'b1101, 7'h00, 1'b1, 2'd1, 0);
    scan_step("ng_d2", 4'b1111, 7'h7F, 1'b1, 2'd2, 0);
    scan_step("ng_d3", 4'b0111, 7'h00, 1'b1, 2'd3, 0);

    // Steps arriving during an 8-cycle guard keep the display dark
    dut_sel = 2;
    digits = 16'h4321;
    blank  = 4'b0000;
    do_reset();
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("rg_an", 32'(o_an), 32'h0F);
        if (c % 8 == 3 || c % 8 == 4)
          check("rg_sel", 32'(o_sel), (c < 4) ? 32'h0 : 32'(((c - 4) / 8) % 4));
      end
      clk_d = ((c / 4) % 2 == 0);
    end

    // Reset while digit 2 is lit
    dut_sel = 0;
    digits = 16'h4321;
    dp_in  = 4'b0010;
    do_reset();
    scan_step("mr_d0", 4'b1110, 7'h79, 1'b1, 2'd0, 2);
    scan_step("mr_d1", 4'b1101, 7'h24, 1'b0, 2'd1, 2);
    scan_step("mr_d2", 4'b1011, 7'h30, 1'b1, 2'd2, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_off("mr_rst");
    prev_an  = 4'hF;
    prev_seg = 7'h7F;
    digits = 16'h0005;
    scan_step("mr_after", 4'b1110, 7'h12, 1'b1, 2'd0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
